// File: rtl/fifo_reader_if.sv
// Handshake bundle between fifo_reader, its source FIFO and the downstream sink.
// master drives FIFO status/data and out_ready; slave is the reader block itself.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
);
    logic                  en;
    logic                  flush;
    logic                  fifo_empty;
    logic [CNT_WIDTH-1:0]  fifo_count;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic [15:0]           rd_count;

    modport master (
        output en, flush, fifo_empty, fifo_count, fifo_data, out_ready,
        input  fifo_rd_en, out_data, out_valid, busy, rd_count
    );

    modport slave (
        input  en, flush, fifo_empty, fifo_count, fifo_data, out_ready,
        output fifo_rd_en, out_data, out_valid, busy, rd_count
    );
endinterface

// File: rtl/fifo_reader.sv
// Drains a registered-output FIFO into a 2-entry buffer; fifo_rd_en -> out_valid in 2 cycles.
// Stalls on out_ready=0 with at most 2 words held; pops again in the same cycle as a handshake.
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int THRESH     = 1
) (
    input  logic         clk,
    input  logic         rst,
    fifo_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    localparam logic [CNT_WIDTH-1:0] THRESH_C = CNT_WIDTH'(THRESH);

    state_t                state;
    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic [15:0]           cnt;
    logic [1:0]            pend;
    logic                  empty_pipe;
    logic                  hs;
    logic                  rd;

    assign pend       = occ + {1'b0, inflight};
    assign empty_pipe = (occ == 2'd0) && !inflight;

    // Gating with rst keeps the pop strobe and status quiet before the first reset edge lands.
    assign bus.out_valid  = rst && (occ != 2'd0);
    assign hs             = bus.out_valid && bus.out_ready;
    assign rd             = rst && (state == DRAIN) && bus.en && !bus.fifo_empty &&
                            ((pend < 2'd2) || ((pend == 2'd2) && hs));
    assign bus.fifo_rd_en = rd;
    assign bus.out_data   = buf0;
    assign bus.busy       = rst && ((state != IDLE) || (occ != 2'd0) || inflight);
    assign bus.rd_count   = cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
            cnt      <= 16'd0;
        end else begin
            inflight <= rd;
            if (hs) begin
                cnt <= cnt + 16'd1;
            end

            // buf0 is always the oldest word; capture and pop together keep occ fixed.
            case ({inflight, hs})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= bus.fifo_data;
                    else             buf1 <= bus.fifo_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= bus.fifo_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= bus.fifo_data;
                    end
                end
                default: ;
            endcase

            unique case (state)
                IDLE: begin
                    if (bus.en) state <= WAIT;
                end
                WAIT: begin
                    if (!bus.en) begin
                        if (empty_pipe) state <= IDLE;
                    end else if ((bus.fifo_count >= THRESH_C) || bus.flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.en) begin
                        if (empty_pipe) state <= IDLE;
                    end else if (bus.fifo_empty && empty_pipe && !bus.flush) begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// Drives two fifo_reader instances (THRESH=1 and THRESH=4) from one FIFO model;
// a negedge monitor pops a word-order scoreboard and tracks handshake counts.
module tb_fifo_reader;
    logic clk = 1'b0;
    logic rst;
    logic sel = 1'b0;
    logic en, flush, out_ready, fifo_empty;
    logic [3:0] fifo_count;
    logic [7:0] fifo_data;

    fifo_reader_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) if0 ();
    fifo_reader_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) if4 ();

    fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4), .THRESH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if0));
    fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4), .THRESH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    assign if0.en = en & ~sel;          assign if4.en = en & sel;
    assign if0.flush = flush;           assign if4.flush = flush;
    assign if0.out_ready = out_ready;   assign if4.out_ready = out_ready;
    assign if0.fifo_empty = fifo_empty; assign if4.fifo_empty = fifo_empty;
    assign if0.fifo_count = fifo_count; assign if4.fifo_count = fifo_count;
    assign if0.fifo_data = fifo_data;   assign if4.fifo_data = fifo_data;

    logic        m_rd_en, m_out_valid, m_busy;
    logic [7:0]  m_out_data;
    logic [15:0] m_rd_count;
    assign m_rd_en     = sel ? if4.fifo_rd_en : if0.fifo_rd_en;
    assign m_out_valid = sel ? if4.out_valid  : if0.out_valid;
    assign m_out_data  = sel ? if4.out_data   : if0.out_data;
    assign m_busy      = sel ? if4.busy       : if0.busy;
    assign m_rd_count  = sel ? if4.rd_count   : if0.rd_count;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int rd_cyc[$];
    int hs_cyc[$];
    logic [7:0] hs_dat[$];
    int cyc = 0;
    int hs_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic update_flags();
        fifo_empty = (fifo_q.size() == 0);
        fifo_count = (fifo_q.size() > 15) ? 4'd15 : 4'(fifo_q.size());
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        update_flags();
    endtask

    // One clock: observe at negedge, then model the FIFO's registered read after the edge.
    task automatic step();
        logic rd_pend;
        @(negedge clk);
        rd_pend = m_rd_en;
        if (m_rd_en) rd_cyc.push_back(cyc);
        if (m_out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            hs_dat.push_back(m_out_data);
            hs_n++;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (rd_pend && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
        update_flags();
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        hs_cyc.delete();
        hs_dat.delete();
    endtask

    task automatic do_reset(input logic new_sel);
        rst = 1'b0; en = 1'b0; flush = 1'b0;
        step();
        sel = new_sel;
        step();
        fifo_q.delete();
        exp_q.delete();
        fifo_data = 8'($urandom);
        update_flags();
        step();
        rst = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: scoreboard order, hold-while-stalled, handshake count, occupancy bound.
    logic        rst_prev = 1'b1;
    logic        stall_prev = 1'b0;
    logic [7:0]  data_prev = 8'd0;
    logic [15:0] hs_cnt0 = 16'd0, hs_cnt4 = 16'd0;
    int          rd_tot = 0, hs_tot = 0;

    always @(negedge clk) begin
        logic [7:0] w;
        if (!rst && !rst_prev) begin
            check("reset_valid", {if0.out_valid, if4.out_valid}, 0);
            check("reset_rd_en", {if0.fifo_rd_en, if4.fifo_rd_en}, 0);
            check("reset_busy", {if0.busy, if4.busy}, 0);
            check("reset_rd_count", {if0.rd_count, if4.rd_count}, 0);
            check("reset_out_data", {if0.out_data, if4.out_data}, 0);
            hs_cnt0 = 16'd0; hs_cnt4 = 16'd0;
            rd_tot = 0; hs_tot = 0;
            stall_prev = 1'b0;
        end else if (rst && rst_prev) begin
            if (stall_prev) begin
                check("hold_valid", m_out_valid, 1);
                check("hold_data", m_out_data, data_prev);
            end
            check("rd_count", m_rd_count, sel ? hs_cnt4 : hs_cnt0);
            check("idle_peer", sel ? {if0.out_valid, if0.fifo_rd_en} : {if4.out_valid, if4.fifo_rd_en}, 0);
            if (m_rd_en) begin
                check("rd_when_empty", fifo_empty, 0);
                rd_tot++;
            end
            if (m_out_valid && out_ready) begin
                hs_tot++;
                if (sel) hs_cnt4 = hs_cnt4 + 16'd1;
                else     hs_cnt0 = hs_cnt0 + 16'd1;
                check("unexpected_word", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("out_data", m_out_data, w);
                end
            end
            check("occupancy", (rd_tot - hs_tot) <= 2, 1);
            stall_prev = m_out_valid && !out_ready;
            data_prev  = m_out_data;
        end
        rst_prev = rst;
    end

    initial begin
        logic [7:0] w0;
        int pushed;
        logic seen_ffff;
        rst = 1'b0; en = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_data = 8'd0;
        update_flags();
        do_reset(1'b0);

        // Preloaded 11/22/33, THRESH=1: three back-to-back reads, words at +2.
        out_ready = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        clear_logs();
        step();
        en = 1'b1;
        repeat (12) step();
        check("t1_reads", rd_cyc.size(), 3);
        check("t1_words", hs_cyc.size(), 3);
        if (rd_cyc.size() == 3 && hs_cyc.size() == 3) begin
            check("t1_rd_consec", rd_cyc[2] - rd_cyc[0], 2);
            check("t1_latency", hs_cyc[0] - rd_cyc[0], 2);
            check("t1_out_consec", hs_cyc[2] - hs_cyc[0], 2);
            check("t1_d0", hs_dat[0], 8'h11);
            check("t1_d1", hs_dat[1], 8'h22);
            check("t1_d2", hs_dat[2], 8'h33);
        end
        check("t1_rd_count", m_rd_count, 3);
        en = 1'b0;
        repeat (3) step();
        check("t1_busy_low", m_busy, 0);

        // THRESH=4 with 3 words waits until flush.
        do_reset(1'b1);
        out_ready = 1'b1;
        repeat (3) push_word(8'($urandom));
        en = 1'b1;
        clear_logs();
        repeat (10) step();
        check("t2_no_reads", rd_cyc.size(), 0);
        check("t2_busy_wait", m_busy, 1);
        check("t2_no_valid", m_out_valid, 0);
        flush = 1'b1;
        drain("t2_drain", 50);
        check("t2_words", hs_cyc.size(), 3);
        flush = 1'b0; en = 1'b0;
        repeat (3) step();
        check("t2_busy_low", m_busy, 0);

        // Backpressure: only two reads while stalled, then 1 word/cycle.
        do_reset(1'b0);
        out_ready = 1'b0;
        w0 = 8'($urandom);
        push_word(w0);
        repeat (4) push_word(8'($urandom));
        en = 1'b1;
        clear_logs();
        repeat (10) step();
        check("t3_stall_reads", rd_cyc.size(), 2);
        check("t3_stall_valid", m_out_valid, 1);
        check("t3_stall_head", m_out_data, w0);
        out_ready = 1'b1;
        drain("t3_drain", 50);
        check("t3_words", hs_cyc.size(), 5);
        if (hs_cyc.size() == 5) check("t3_rate", hs_cyc[4] - hs_cyc[0], 4);

        // en dropped with one word buffered and one in flight.
        do_reset(1'b0);
        out_ready = 1'b0;
        repeat (5) push_word(8'($urandom));
        en = 1'b1;
        clear_logs();
        for (int i = 0; i < 20 && rd_cyc.size() < 2; i++) step();
        check("t4_setup", rd_cyc.size(), 2);
        en = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        check("t4_reads", rd_cyc.size(), 2);
        check("t4_words", hs_cyc.size(), 2);
        check("t4_left", exp_q.size(), 3);
        check("t4_busy_low", m_busy, 0);

        // Reset right after a read discards the in-flight word.
        do_reset(1'b0);
        out_ready = 1'b1;
        push_word(8'($urandom)); push_word(8'($urandom));
        en = 1'b1;
        drain("t5_pre", 30);
        repeat (4) push_word(8'($urandom));
        clear_logs();
        for (int i = 0; i < 20 && rd_cyc.size() < 1; i++) step();
        check("t5_setup", rd_cyc.size() >= 1, 1);
        rst = 1'b0;
        step();
        step();
        check("t5_valid", m_out_valid, 0);
        check("t5_rd_count", m_rd_count, 0);
        check("t5_busy", m_busy, 0);
        do_reset(1'b0);
        en = 1'b1;
        clear_logs();
        repeat (6) step();
        check("t5_no_capture", hs_cyc.size(), 0);

        // Randomized traffic on both thresholds.
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0]);
            for (int i = 0; i < 1500; i++) begin
                en        = ($urandom_range(0, 9) != 0);
                flush     = ($urandom_range(0, 7) == 0);
                out_ready = ($urandom_range(0, 3) != 0);
                if (fifo_q.size() < 10 && $urandom_range(0, 1) == 1) push_word(8'($urandom));
                step();
            end
            en = 1'b1; flush = 1'b1; out_ready = 1'b1;
            drain("rand_drain", 300);
            en = 1'b0; flush = 1'b0;
            repeat (4) step();
            check("rand_busy_low", m_busy, 0);
        end

        // rd_count wraps after 65536 handshakes.
        do_reset(1'b0);
        en = 1'b1; out_ready = 1'b1; flush = 1'b0;
        pushed = 0; hs_n = 0; seen_ffff = 1'b0;
        for (int k = 0; k < 70000 && hs_n < 65536; k++) begin
            if (pushed < 65536 && fifo_q.size() < 6) begin
                push_word(8'(pushed));
                pushed++;
            end
            step();
            if (hs_n == 65535 && !seen_ffff) begin
                check("wrap_ffff", m_rd_count, 16'hFFFF);
                seen_ffff = 1'b1;
            end
            if (k % 4096 == 0) clear_logs();
        end
        check("wrap_handshakes", hs_n, 65536);
        check("wrap_zero", m_rd_count, 16'h0000);
        en = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO and output data.
REQ-002 Parameter CNT_WIDTH, default 4, width of the FIFO occupancy count input.
REQ-003 Parameter THRESH, default 1, minimum FIFO occupancy that starts a drain.
REQ-004 clk  input  1  system clock; all state SHALL update on the rising edge only.
REQ-005 rst  input  1  reset; one clock, synchronous, active-low: reset SHALL be applied on a rising clk edge while rst==0.
REQ-006 en  input  1  enable; 1 allows new FIFO reads.
REQ-007 flush  input  1  drain regardless of THRESH.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_count  input  CNT_WIDTH  FIFO occupancy.
REQ-010 fifo_data  input  DATA_WIDTH  FIFO registered read data, valid the cycle after fifo_rd_en.
REQ-011 fifo_rd_en  output  1  FIFO pop request.
REQ-012 out_data  output  DATA_WIDTH  downstream data.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 busy  output  1  block not idle or data still held.
REQ-016 rd_count  output  16  count of completed downstream handshakes.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, DRAIN.
REQ-018 IDLE->WAIT when en==1; WAIT->DRAIN when en==1 and (fifo_count>=THRESH or flush==1).
REQ-019 DRAIN->WAIT when fifo_empty==1, no read in flight, buffer empty, flush==0.
REQ-020 WAIT or DRAIN->IDLE when en==0, no read in flight, buffer empty; with en==0 otherwise, state SHALL hold and no new reads SHALL issue.
REQ-021 Output buffer SHALL hold 2 entries, FIFO ordered; inflight SHALL be fifo_rd_en registered one cycle.
REQ-022 fifo_rd_en SHALL be 1 only when state==DRAIN, en==1, fifo_empty==0, and (occ+inflight<2, or occ+inflight==2 with a handshake this cycle).
REQ-023 fifo_rd_en SHALL be combinational; out_ready->fifo_rd_en path is permitted.
REQ-024 When inflight==1, fifo_data SHALL be written into the buffer on that edge.
REQ-025 Latency: fifo_rd_en high in cycle N -> out_valid high with that word in cycle N+2 (if buffer otherwise empty).
REQ-026 out_valid SHALL equal (occ!=0); out_data SHALL be the oldest entry; both SHALL hold stable while out_valid==1 and out_ready==0.
REQ-027 Handshake = out_valid & out_ready; it SHALL pop one entry; simultaneous capture and pop SHALL leave occ unchanged.
REQ-028 Sustained throughput SHALL be 1 word/cycle when FIFO non-empty and out_ready==1.
REQ-029 Occupancy SHALL never exceed 2; no word SHALL be dropped or duplicated.
REQ-030 rd_count SHALL increment by 1 per handshake, wrapping 16'hFFFF->16'h0000.
REQ-031 busy SHALL equal (state!=IDLE) | (occ!=0) | inflight.
REQ-032 fifo_empty SHALL be ignored outside DRAIN; fifo_data SHALL be ignored when inflight==0.

Reset
REQ-033 On reset: state=IDLE, occ=0, inflight=0, fifo_rd_en=0, out_valid=0, out_data=0, rd_count=0, busy=0.
REQ-034 Reset mid-operation SHALL discard buffered and in-flight data; fifo_data arriving the cycle after reset SHALL not be captured.
REQ-035 Outputs SHALL remain at reset values while rst==0 regardless of other inputs.

Verification
REQ-036 FIFO preloaded 8'h11,8'h22,8'h33, THRESH=1, out_ready=1, en 0->1 -> fifo_rd_en high 3 consecutive cycles; out_data 11,22,33 on consecutive cycles, first 2 cycles after first fifo_rd_en; rd_count=3; busy falls after last word.
REQ-037 THRESH=4, FIFO holds 3 words, flush=0 -> state stays WAIT, no fifo_rd_en; assert flush -> 3 words delivered in order.
REQ-038 out_ready=0 with 5 words in FIFO -> exactly 2 reads issued, out_valid=1, out_data stable; out_ready=1 -> remaining 3 words follow at 1 word/cycle, order intact.
REQ-039 en dropped during DRAIN with 1 word in flight and 1 buffered -> no further fifo_rd_en; both words delivered; then state=IDLE, busy=0.
REQ-040 rst=0 asserted the cycle after fifo_rd_en -> next cycle out_valid=0, rd_count=0, nothing captured.
REQ-041 rd_count preset by 65535 handshakes, one more handshake -> rd_count=16'h0000.
